// File: rtl/usr_pkg.sv
// Shared types and encodings for the universal shift register.
// Defines operation modes (HOLD/LOAD/SHL/SHR), burst FSM states, and mode encodings.
// No ports; imported by usr_next_val and universal_shift_reg.
package usr_pkg;

    // Mode encodings as they appear on the 2-bit mode input.
    localparam logic [1:0] MODE_ENC_HOLD = 2'b00;
    localparam logic [1:0] MODE_ENC_LOAD = 2'b01;
    localparam logic [1:0] MODE_ENC_SHL  = 2'b10;
    localparam logic [1:0] MODE_ENC_SHR  = 2'b11;

    typedef enum logic [1:0] {
        HOLD = MODE_ENC_HOLD,
        LOAD = MODE_ENC_LOAD,
        SHL  = MODE_ENC_SHL,
        SHR  = MODE_ENC_SHR
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Shift modes are the two encodings with the MSB set.
    function automatic logic is_shift_mode(input logic [1:0] m);
        return m[1];
    endfunction

    // For a shift mode, bit 0 selects the right-shift direction.
    function automatic logic is_right_dir(input logic [1:0] m);
        return m[0];
    endfunction

endpackage

// File: rtl/usr_next_val.sv
// Combinational next-value and serial-out mux for the universal shift register.
// Ports: i_q current contents, i_d load data, i_sin serial in, i_rot rotate select,
//        i_op effective operation, i_sout_lsb serial-out tap select; o_q_nxt, o_sout.
// Optional feature macro: USR_ROTATE_EN (rot=1 recirculates the outgoing bit).
module usr_next_val
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin,
    input  logic             i_rot,
    input  mode_t            i_op,
    input  logic             i_sout_lsb,
    output logic [WIDTH-1:0] o_q_nxt,
    output logic             o_sout
);

    logic             w_shl_in;
    logic             w_shr_in;
    logic [WIDTH-1:0] w_shl_val;
    logic [WIDTH-1:0] w_shr_val;

`ifdef USR_ROTATE_EN
    // Rotate feeds back the bit that leaves the register on this edge.
    assign w_shl_in = i_rot ? i_q[WIDTH-1] : i_sin;
    assign w_shr_in = i_rot ? i_q[0]       : i_sin;
`else
    logic w_unused_rot;
    assign w_unused_rot = i_rot;
    assign w_shl_in     = i_sin;
    assign w_shr_in     = i_sin;
`endif

    // A 1-bit register has no bits to carry across, so both shifts
    // degenerate to loading the incoming bit.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shl_val = w_shl_in;
            assign w_shr_val = w_shr_in;
        end else begin : g_wn
            assign w_shl_val = {i_q[WIDTH-2:0], w_shl_in};
            assign w_shr_val = {w_shr_in, i_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        o_q_nxt = i_q;
        case (i_op)
            HOLD:    o_q_nxt = i_q;
            LOAD:    o_q_nxt = i_d;
            SHL:     o_q_nxt = w_shl_val;
            SHR:     o_q_nxt = w_shr_val;
            default: o_q_nxt = i_q;
        endcase
    end

    // Serial out shows the bit the next shift in that direction would drop.
    assign o_sout = i_sout_lsb ? i_q[0] : i_q[WIDTH-1];

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/load/shift-left/shift-right plus a WIDTH-bit serial burst engine.
// Ports: clock, reset (async active-high), i_mode, i_start, i_d, i_sin, i_rot;
//        o_q contents, o_sout serial out, o_busy burst in progress, o_done 1-cycle completion pulse.
// Optional feature macro: USR_ROTATE_EN (enables i_rot rotate behaviour in usr_next_val).
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       i_mode,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin,
    input  logic             i_rot,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout,
    output logic             o_busy,
    output logic             o_done
);

    // Burst counter must be able to hold WIDTH itself.
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    mode_t              r_dir;
    mode_t              w_dir_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               r_busy;
    logic               r_done;
    mode_t              w_op;
    logic               w_sout_lsb;
    logic               w_start_ok;

    // A start is only honoured from IDLE and only with a shift mode;
    // with HOLD/LOAD it is simply ignored.
    assign w_start_ok = i_start && is_shift_mode(i_mode);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_dir   <= SHL;
            r_count <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_count <= w_count_nxt;
            r_q     <= w_q_nxt;
            // Status flags are registered from the next state so they align
            // exactly with the state they describe.
            r_busy  <= (w_state_nxt == SHIFT);
            r_done  <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_count_nxt = r_count;
        w_op        = HOLD;
        w_sout_lsb  = is_right_dir(r_dir);
        case (r_state)
            IDLE: begin
                w_op       = mode_t'(i_mode);
                w_sout_lsb = i_mode[0];
                if (w_start_ok) begin
                    // The first burst shift happens on the accepting edge.
                    w_dir_nxt   = mode_t'(i_mode);
                    w_count_nxt = CNT_W'(1);
                    w_state_nxt = (WIDTH == 1) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // Mode input is ignored mid-burst; the latched direction rules.
                w_op        = r_dir;
                w_count_nxt = r_count + CNT_W'(1);
                if (r_count == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_op        = HOLD;
                w_count_nxt = '0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_op        = HOLD;
                w_count_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    usr_next_val #(
        .WIDTH(WIDTH)
    ) u_next_val (
        .i_q        (r_q),
        .i_d        (i_d),
        .i_sin      (i_sin),
        .i_rot      (i_rot),
        .i_op       (w_op),
        .i_sout_lsb (w_sout_lsb),
        .o_q_nxt    (w_q_nxt),
        .o_sout     (o_sout)
    );

    assign o_q    = r_q;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;
    localparam int WIDTH = 8;
`ifdef USR_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       mode;
    logic             start;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic             rot;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: contents, remaining burst shifts, direction, done flag.
    logic [WIDTH-1:0] m_q;
    int               m_left;
    bit               m_right;
    bit               m_done;
    logic             exp_sout_pre;
    logic             got_sout_pre;

    always #5 clock = ~clock;

    universal_shift_reg #(.WIDTH(WIDTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .i_mode  (mode),
        .i_start (start),
        .i_d     (d),
        .i_sin   (sin),
        .i_rot   (rot),
        .o_q     (q),
        .o_sout  (sout),
        .o_busy  (busy),
        .o_done  (done)
    );

    function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] v, input bit right,
                                                 input logic s, input logic r);
        logic out_bit;
        logic in_bit;
        out_bit = right ? v[0] : v[WIDTH-1];
        in_bit  = (ROT_EN && r) ? out_bit : s;
        if (right) return (v >> 1) | ({{(WIDTH-1){1'b0}}, in_bit} << (WIDTH-1));
        else       return (v << 1) | {{(WIDTH-1){1'b0}}, in_bit};
    endfunction

    task automatic model_reset();
        m_q = '0; m_left = 0; m_right = 1'b0; m_done = 1'b0;
    endtask

    // One clock: drive at negedge, record sout before the edge, update model after it.
    task automatic step(input logic [1:0] md, input logic st, input logic [WIDTH-1:0] dd,
                        input logic s, input logic r);
        bit right_now;
        @(negedge clock);
        mode = md; start = st; d = dd; sin = s; rot = r;
        #1;
        right_now    = (m_left > 0 || m_done) ? m_right : md[0];
        exp_sout_pre = right_now ? m_q[0] : m_q[WIDTH-1];
        got_sout_pre = sout;
        @(posedge clock);
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            m_q = shifted(m_q, m_right, s, r);
            m_left--;
            if (m_left == 0) m_done = 1'b1;
        end else begin
            case (md)
                2'b01:   m_q = dd;
                2'b10:   m_q = shifted(m_q, 1'b0, s, r);
                2'b11:   m_q = shifted(m_q, 1'b1, s, r);
                default: ;
            endcase
            if (st && md[1]) begin
                m_right = md[0];
                m_left  = WIDTH - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want 00", q); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout: got %b want 0", sout); end
        @(negedge clock); reset = 1'b0;
        model_reset();
        step(2'b01, 1'b0, 8'hA5, 1'b0, 1'b0);
        n_checks++; if (q !== 8'hA5) begin n_fail++; $display("FAIL load_a5: got %h want a5", q); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL async_reset_q: got %h want 00", q); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: got busy=%b done=%b want 0 0", busy, done); end
        model_reset();
        mode = 2'b00; start = 1'b0;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_load_hold_shift();
        step(2'b01, 1'b0, 8'h3C, 1'b0, 1'b0);
        n_checks++; if (q !== 8'h3C) begin n_fail++; $display("FAIL load_3c: got %h want 3c", q); end
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0, 8'hFF, 1'b1, 1'b0);
            n_checks++; if (q !== 8'h3C) begin n_fail++; $display("FAIL hold_%0d: got %h want 3c", i, q); end
        end
        step(2'b10, 1'b0, 8'h00, 1'b1, 1'b0);
        n_checks++; if (got_sout_pre !== 1'b0) begin n_fail++; $display("FAIL shl_sout: got %b want 0", got_sout_pre); end
        n_checks++; if (q !== 8'h79) begin n_fail++; $display("FAIL shl_q: got %h want 79", q); end
    endtask

    task automatic test_burst_shr();
        logic [7:0] seq;
        seq = 8'b1111_0000;
        step(2'b01, 1'b0, 8'hF0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 1) step(2'b11, 1'b1, 8'h00, 1'b0, 1'b0);
            else        step(2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
            if (k <= 8) begin
                n_checks++; if (got_sout_pre !== seq[k-1]) begin n_fail++; $display("FAIL shr_sout_%0d: got %b want %b", k, got_sout_pre, seq[k-1]); end
            end
            n_checks++; if (busy !== (k < 8)) begin n_fail++; $display("FAIL shr_busy_%0d: got %b want %b", k, busy, (k < 8)); end
            n_checks++; if (done !== (k == 8)) begin n_fail++; $display("FAIL shr_done_%0d: got %b want %b", k, done, (k == 8)); end
            n_checks++; if (q !== m_q) begin n_fail++; $display("FAIL shr_q_%0d: got %h want %h", k, q, m_q); end
        end
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL shr_final: got %h want 00", q); end
    endtask

    task automatic test_ignored_start();
        step(2'b01, 1'b0, 8'h5A, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 1)      step(2'b10, 1'b1, 8'h00, 1'b0, 1'b0);
            else if (k == 4) step(2'b01, 1'b1, 8'hFF, 1'b0, 1'b0);
            else             step(2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
            n_checks++; if (q !== m_q) begin n_fail++; $display("FAIL ign_q_%0d: got %h want %h", k, q, m_q); end
            n_checks++; if (busy !== (k < 8) || done !== (k == 8)) begin n_fail++; $display("FAIL ign_flags_%0d: got busy=%b done=%b", k, busy, done); end
        end
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("FAIL ign_final: got %h want 00", q); end
    endtask

    task automatic test_reset_mid_burst();
        logic s;
        step(2'b01, 1'b0, 8'hA5, 1'b0, 1'b0);
        step(2'b10, 1'b1, 8'h00, 1'b1, 1'b0);
        step(2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
        step(2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset: got q=%h busy=%b done=%b want 00 0 0", q, busy, done); end
        model_reset();
        mode = 2'b00; start = 1'b0;
        @(negedge clock); reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            s = 1'($urandom_range(0, 1));
            if (k == 1) step(2'b11, 1'b1, 8'h00, s, 1'b0);
            else        step(2'b10, 1'b0, 8'h00, s, 1'b0);
            n_checks++; if (done !== (k == 8)) begin n_fail++; $display("FAIL rb_done_%0d: got %b want %b", k, done, (k == 8)); end
            n_checks++; if (q !== m_q || busy !== (k < 8)) begin n_fail++; $display("FAIL rb_state_%0d: got q=%h busy=%b want %h %b", k, q, busy, m_q, (k < 8)); end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 20; k++) begin
            step(2'b10, 1'b1, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
            n_checks++; if (done !== ((k % 9) == 8)) begin n_fail++; $display("FAIL b2b_done_%0d: got %b want %b", k, done, ((k % 9) == 8)); end
            n_checks++; if (q !== m_q || busy !== (m_left > 0)) begin n_fail++; $display("FAIL b2b_state_%0d: got q=%h busy=%b want %h %b", k, q, busy, m_q, (m_left > 0)); end
        end
        step(2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 8'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n_checks++;
            if (q !== m_q || busy !== (m_left > 0) || done !== m_done || got_sout_pre !== exp_sout_pre) begin
                n_fail++;
                $display("FAIL rand_%0d: got q=%h busy=%b done=%b sout=%b want %h %b %b %b",
                         i, q, busy, done, got_sout_pre, m_q, (m_left > 0), m_done, exp_sout_pre);
            end
        end
        for (int i = 0; i < 10; i++) step(2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

`ifdef USR_ROTATE_EN
    task automatic test_rotate();
        step(2'b01, 1'b0, 8'h81, 1'b0, 1'b0);
        step(2'b10, 1'b0, 8'h00, 1'b0, 1'b1);
        n_checks++; if (q !== 8'h03) begin n_fail++; $display("FAIL rot_single: got %h want 03", q); end
        step(2'b01, 1'b0, 8'h81, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step((k == 1) ? 2'b10 : 2'b00, (k == 1), 8'h00, 1'b0, 1'b1);
        end
        n_checks++; if (q !== 8'h81 || done !== 1'b1) begin n_fail++; $display("FAIL rot_burst: got q=%h done=%b want 81 1", q, done); end
        step(2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        reset = 1'b1; mode = 2'b00; start = 1'b0; d = '0; sin = 1'b0; rot = 1'b0;
        model_reset();
        test_reset();
        test_load_hold_shift();
        test_burst_shr();
        test_ignored_start();
        test_reset_mid_burst();
        test_back_to_back();
`ifdef USR_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
